i2c_codec_target: RTL

I2C write-only target (responder) that models the audio-codec end of the configuration bus. It oversamples SCL/SDA on the system clock, detects START/STOP, matches its 7-bit device address and acknowledges 3-byte write transactions. Each transaction carries one 16-bit control word `{reg[6:0], data[8:0]}`, which it presents as a write strobe and stores in a 16-entry shadow register file. It sits opposite the codec configuration master, for loopback verification and as a codec stand-in during bring-up.

---
 rtl/i2c_codec_target.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_codec_target.sv
// ============================================================================
// i2c_codec_target : write-only I2C target capturing 16-bit codec control words
// Revision 1.0
// ============================================================================
`default_nettype none

module i2c_codec_target #(
    parameter logic [6:0] I2C_ADDR = 7'h1A,
    parameter int         FILT_LEN = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSCL,
    input  logic       iSDA,
    output logic       oSDA_OE,
    output logic       oWR_STB,
    output logic [6:0] oWR_ADDR,
    output logic [8:0] oWR_DATA,
    input  logic [3:0] iRD_ADDR,
    output logic [8:0] oRD_DATA,
    output logic       oBUSY
);

    localparam logic [3:0] C_FILT_MAX  = 4'(FILT_LEN - 1);
    localparam logic [7:0] C_ADDR_BYTE = {I2C_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_WAIT_STOP
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA.
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic [1:0] w_prev;

    assign w_raw = {iSDA, iSCL};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_filt
        logic       s1_q, s2_q, f_q, fp_q;
        logic [3:0] cnt_q;

        always_ff @(posedge iCLK or posedge iRST) begin
            if (iRST) begin
                s1_q  <= 1'b1;
                s2_q  <= 1'b1;
                f_q   <= 1'b1;
                fp_q  <= 1'b1;
                cnt_q <= 4'd0;
            end else begin
                s1_q <= w_raw[gi];
                s2_q <= s1_q;
                fp_q <= f_q;
                if (s2_q == f_q) begin
                    cnt_q <= 4'd0;
                end else if (cnt_q == C_FILT_MAX) begin
                    f_q   <= s2_q;
                    cnt_q <= 4'd0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end

        assign w_filt[gi] = f_q;
        assign w_prev[gi] = fp_q;
    end

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl      = w_filt[0];
    assign w_sda      = w_filt[1];
    assign w_scl_rise =  w_filt[0] & ~w_prev[0];
    assign w_scl_fall = ~w_filt[0] &  w_prev[0];
    // Bus conditions are qualified by SCL having been high before and after the SDA edge.
    assign w_start    = ~w_filt[1] &  w_prev[1] & w_scl & w_prev[0];
    assign w_stop     =  w_filt[1] & ~w_prev[1] & w_scl & w_prev[0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte1_q, byte1_d;
    logic        oe_q, oe_d;
    logic        stb_q, stb_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [8:0]  wr_data_q, wr_data_d;
    logic        w_shadow_we;
    logic [15:0] w_word;
    logic [8:0]  shadow_q [16];

    assign w_word = {byte1_q, shift_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        byte1_d     = byte1_q;
        oe_d        = oe_q;
        stb_d       = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        w_shadow_we = 1'b0;
        if (w_stop) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else if (w_start) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (w_scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], w_sda};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (w_scl_fall && cnt_q == 4'd8) begin
                        oe_d = 1'b1;
                        if (state_q == S_ADDR) begin
                            if (shift_q == C_ADDR_BYTE) begin
                                state_d = S_ACK_A;
                            end else begin
                                state_d = S_WAIT_STOP;
                                oe_d    = 1'b0;
                            end
                        end else if (state_q == S_BYTE1) begin
                            byte1_d = shift_q;
                            state_d = S_ACK_1;
                        end else begin
                            state_d     = S_ACK_2;
                            stb_d       = 1'b1;
                            wr_addr_d   = w_word[15:9];
                            wr_data_d   = w_word[8:0];
                            w_shadow_we = (w_word[15:13] == 3'd0);
                        end
                    end
                end
                S_ACK_A, S_ACK_1, S_ACK_2: begin
                    if (w_scl_fall) begin
                        oe_d  = 1'b0;
                        cnt_d = 4'd0;
                        case (state_q)
                            S_ACK_A: state_d = S_BYTE1;
                            S_ACK_1: state_d = S_BYTE2;
                            default: state_d = S_WAIT_STOP;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 8'd0;
            byte1_q   <= 8'd0;
            oe_q      <= 1'b0;
            stb_q     <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= 9'd0;
            for (int i = 0; i < 16; i++) shadow_q[i] <= 9'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            byte1_q   <= byte1_d;
            oe_q      <= oe_d;
            stb_q     <= stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            if (w_shadow_we) shadow_q[w_word[12:9]] <= w_word[8:0];
        end
    end

    assign oSDA_OE  = oe_q;
    assign oWR_STB  = stb_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oRD_DATA = shadow_q[iRD_ADDR];
    assign oBUSY    = (state_q != S_IDLE);

endmodule

`default_nettype wire
